// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package reg_file_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int DEPTH_DEF  = 2**ADDR_W_DEF;
   localparam int MAX_DEPTH  = 256;

   // Callers zero-extend their busy vector to MAX_DEPTH bits.
   function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

endpackage

// File: rtl/reg_file_bypass_mux.sv
// One read port: compares the read address against every write port and
// forwards the highest-indexed matching write, else the stored word.
module reg_file_bypass_mux #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_WR = 2
)(
   input  logic [ADDR_W-1:0]        i_rd_addr,
   input  logic [NUM_WR-1:0]        i_wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
   input  logic [DATA_W-1:0]        i_mem_data,
   output logic [DATA_W-1:0]        o_data,
   output logic                     o_hit
);

   always_comb begin
      o_data = i_mem_data;
      o_hit  = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
         if (i_wr_en[j] && i_wr_addr[j*ADDR_W +: ADDR_W] == i_rd_addr) begin
            o_hit  = 1'b1;
            o_data = i_wr_data[j*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with write-to-read bypass and per-register busy scoreboard.
// Optional debug read port enabled by defining REG_FILE_DEBUG_PORT_EN.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1
)(
   input  logic                     clk,
   input  logic                     SYS_reset_n,
   input  logic [NUM_RD*ADDR_W-1:0] REG_rd_addr,
   output logic [NUM_RD*DATA_W-1:0] REG_rd_data,
   output logic [NUM_RD-1:0]        REG_rd_ready,
   input  logic [NUM_WR-1:0]        REG_wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] REG_wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] REG_wr_data,
   input  logic                     REG_issue_valid,
   input  logic [ADDR_W-1:0]        REG_issue_addr,
   output logic                     REG_issue_ready,
   input  logic                     REG_flush,
   output logic [ADDR_W:0]          REG_busy_cnt
`ifdef REG_FILE_DEBUG_PORT_EN
   ,
   input  logic [ADDR_W-1:0]        REG_dbg_addr,
   output logic [DATA_W-1:0]        REG_dbg_data
`endif
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int CNT_W = ADDR_W + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_busy;
   logic [CNT_W-1:0]  r_busy_cnt;
   logic [NUM_WR-1:0] w_wr_eff;
   logic              w_issue_hit;
   logic              w_issue_fire;
   logic [DEPTH-1:0]  w_busy_nxt;

   // Writes to a hardwired r0 are dropped before they reach bypass or scoreboard.
   always_comb begin
      for (int j = 0; j < NUM_WR; j++) begin
         w_wr_eff[j] = REG_wr_en[j] &&
                       !(ZERO_REG != 0 && REG_wr_addr[j*ADDR_W +: ADDR_W] == '0);
      end
   end

   always_comb begin
      w_issue_hit = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
         if (w_wr_eff[j] && REG_wr_addr[j*ADDR_W +: ADDR_W] == REG_issue_addr)
            w_issue_hit = 1'b1;
      end
   end

   assign REG_issue_ready = !REG_flush && (!r_busy[REG_issue_addr] || w_issue_hit);
   assign w_issue_fire    = REG_issue_valid && REG_issue_ready &&
                            !(ZERO_REG != 0 && REG_issue_addr == '0);

   // Issue is applied after write-back clears so it wins on a same-address collision.
   always_comb begin
      w_busy_nxt = r_busy;
      for (int j = 0; j < NUM_WR; j++) begin
         if (w_wr_eff[j]) w_busy_nxt[REG_wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
      end
      if (w_issue_fire) w_busy_nxt[REG_issue_addr] = 1'b1;
      if (REG_flush)    w_busy_nxt = '0;
   end

   always_ff @(posedge clk or negedge SYS_reset_n) begin
      if (!SYS_reset_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_busy     <= '0;
         r_busy_cnt <= '0;
      end else begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (w_wr_eff[j])
               r_mem[REG_wr_addr[j*ADDR_W +: ADDR_W]] <= REG_wr_data[j*DATA_W +: DATA_W];
         end
         r_busy     <= w_busy_nxt;
         r_busy_cnt <= CNT_W'(popcount(MAX_DEPTH'(w_busy_nxt)));
      end
   end

   assign REG_busy_cnt = r_busy_cnt;

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic w_hit;

      reg_file_bypass_mux #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .NUM_WR (NUM_WR)
      ) u_mux (
         .i_rd_addr  (REG_rd_addr[k*ADDR_W +: ADDR_W]),
         .i_wr_en    (w_wr_eff),
         .i_wr_addr  (REG_wr_addr),
         .i_wr_data  (REG_wr_data),
         .i_mem_data (r_mem[REG_rd_addr[k*ADDR_W +: ADDR_W]]),
         .o_data     (REG_rd_data[k*DATA_W +: DATA_W]),
         .o_hit      (w_hit)
      );

      assign REG_rd_ready[k] = w_hit || !r_busy[REG_rd_addr[k*ADDR_W +: ADDR_W]];
   end

`ifdef REG_FILE_DEBUG_PORT_EN
   assign REG_dbg_data = (ZERO_REG != 0 && REG_dbg_addr == '0) ? '0 : r_mem[REG_dbg_addr];
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: stimulus pushes model predictions, a monitor pops and compares.
module tb_reg_file_sb;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int NW = 2;
   localparam int DEPTH = 32;

   logic              clk = 1'b0;
   logic              SYS_reset_n;
   logic [NR*AW-1:0]  rd_addr;
   logic [NR*DW-1:0]  rd_data;
   logic [NR-1:0]     rd_ready;
   logic [NW-1:0]     wr_en;
   logic [NW*AW-1:0]  wr_addr;
   logic [NW*DW-1:0]  wr_data;
   logic              issue_valid;
   logic [AW-1:0]     issue_addr;
   logic              issue_ready;
   logic              flush;
   logic [AW:0]       busy_cnt;

   always #5 clk = ~clk;

   reg_file_sb #(
      .DATA_W (DW), .ADDR_W (AW), .NUM_RD (NR), .NUM_WR (NW), .ZERO_REG (1)
   ) dut (
      .clk             (clk),
      .SYS_reset_n     (SYS_reset_n),
      .REG_rd_addr     (rd_addr),
      .REG_rd_data     (rd_data),
      .REG_rd_ready    (rd_ready),
      .REG_wr_en       (wr_en),
      .REG_wr_addr     (wr_addr),
      .REG_wr_data     (wr_data),
      .REG_issue_valid (issue_valid),
      .REG_issue_addr  (issue_addr),
      .REG_issue_ready (issue_ready),
      .REG_flush       (flush),
      .REG_busy_cnt    (busy_cnt)
   );

   typedef struct {
      int              id;
      logic [NR*DW-1:0] data;
      logic [NR-1:0]    rdy;
      logic             iss;
      logic [AW:0]      cnt;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad   = 0;
   int step  = 0;

   // Reference state: what the architectural register file should hold.
   logic [DW-1:0] m_mem  [DEPTH];
   bit            m_busy [DEPTH];

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i]  = '0;
         m_busy[i] = 1'b0;
      end
   endfunction

   function automatic bit write_hits(input int a);
      for (int j = 0; j < NW; j++)
         if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a && a != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic exp_t model_expect();
      exp_t e;
      int n;
      e.id = step;
      for (int k = 0; k < NR; k++) begin
         int a;
         a = int'(rd_addr[k*AW +: AW]);
         e.data[k*DW +: DW] = m_mem[a];
         e.rdy[k] = !m_busy[a];
         if (a == 0) begin
            e.data[k*DW +: DW] = '0;
            e.rdy[k] = 1'b1;
         end else begin
            for (int j = 0; j < NW; j++) begin
               if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) begin
                  e.data[k*DW +: DW] = wr_data[j*DW +: DW];
                  e.rdy[k] = 1'b1;
               end
            end
         end
      end
      e.iss = !flush && (!m_busy[int'(issue_addr)] || write_hits(int'(issue_addr)));
      n = 0;
      for (int i = 0; i < DEPTH; i++) if (m_busy[i]) n++;
      e.cnt = (AW+1)'(n);
      return e;
   endfunction

   // Drive one cycle of inputs (just after posedge), predict, then advance the model at the edge.
   task automatic drive(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                        input logic [1:0] we,
                        input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                        input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                        input logic iv, input logic [AW-1:0] ia, input logic fl);
      exp_t e;
      rd_addr     = {ra1, ra0};
      wr_en       = we;
      wr_addr     = {wa1, wa0};
      wr_data     = {wd1, wd0};
      issue_valid = iv;
      issue_addr  = ia;
      flush       = fl;
      step++;
      e = model_expect();
      q.push_back(e);
      @(posedge clk);
      if (SYS_reset_n) begin
         for (int j = 0; j < NW; j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] != '0) begin
               m_mem[int'(wr_addr[j*AW +: AW])]  = wr_data[j*DW +: DW];
               m_busy[int'(wr_addr[j*AW +: AW])] = 1'b0;
            end
         end
         if (issue_valid && e.iss && issue_addr != '0) m_busy[int'(issue_addr)] = 1'b1;
         if (flush) for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
      end
      #1;
   endtask

   task automatic idle_read(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
      drive(ra0, ra1, 2'b00, '0, '0, '0, '0, 1'b0, '0, 1'b0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (rd_data !== e.data) begin
               bad++;
               $display("FAIL step%0d rd_data got=%h exp=%h", e.id, rd_data, e.data);
            end
            total++;
            if (rd_ready !== e.rdy) begin
               bad++;
               $display("FAIL step%0d rd_ready got=%b exp=%b", e.id, rd_ready, e.rdy);
            end
            total++;
            if (issue_ready !== e.iss) begin
               bad++;
               $display("FAIL step%0d issue_ready got=%b exp=%b", e.id, issue_ready, e.iss);
            end
            total++;
            if (busy_cnt !== e.cnt) begin
               bad++;
               $display("FAIL step%0d busy_cnt got=%0d exp=%0d", e.id, busy_cnt, e.cnt);
            end
         end
      end
   end

   initial begin : stimulus
      exp_t e;
      SYS_reset_n = 1'b0;
      rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
      issue_valid = 1'b0; issue_addr = '0; flush = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 SYS_reset_n = 1'b1;

      idle_read(5'd5, 5'd0);
      drive(5'd7, 5'd7, 2'b00, '0, '0, '0, '0, 1'b1, 5'd7, 1'b0);
      idle_read(5'd7, 5'd0);
      drive(5'd7, 5'd7, 2'b01, 5'd7, '0, 32'hDEADBEEF, '0, 1'b0, '0, 1'b0);
      idle_read(5'd7, 5'd0);
      drive(5'd3, 5'd3, 2'b11, 5'd3, 5'd3, 32'h11, 32'h22, 1'b0, '0, 1'b0);
      idle_read(5'd3, 5'd0);

      drive(5'd9, 5'd9, 2'b00, '0, '0, '0, '0, 1'b1, 5'd9, 1'b0);
      drive(5'd9, 5'd0, 2'b00, '0, '0, '0, '0, 1'b1, 5'd9, 1'b0);
      drive(5'd9, 5'd0, 2'b10, '0, 5'd9, '0, 32'h99, 1'b1, 5'd9, 1'b0);
      idle_read(5'd9, 5'd0);

      drive(5'd1, 5'd2, 2'b00, '0, '0, '0, '0, 1'b1, 5'd1, 1'b0);
      drive(5'd1, 5'd2, 2'b00, '0, '0, '0, '0, 1'b1, 5'd2, 1'b0);
      drive(5'd1, 5'd2, 2'b00, '0, '0, '0, '0, 1'b1, 5'd4, 1'b0);
      drive(5'd2, 5'd4, 2'b01, 5'd2, '0, 32'h5, '0, 1'b1, 5'd6, 1'b1);
      idle_read(5'd2, 5'd6);

      drive(5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b0);
      idle_read(5'd0, 5'd0);

      drive(5'd4, 5'd0, 2'b00, '0, '0, '0, '0, 1'b1, 5'd4, 1'b0);
      idle_read(5'd4, 5'd0);
      // Mid-cycle reset: state must clear without waiting for an edge.
      SYS_reset_n = 1'b0;
      model_reset();
      rd_addr = {5'd7, 5'd4}; wr_en = '0; issue_valid = 1'b0; flush = 1'b0;
      step++;
      e = model_expect();
      q.push_back(e);
      @(posedge clk);
      #1 SYS_reset_n = 1'b1;
      idle_read(5'd7, 5'd3);

      repeat (400) begin
         logic [AW-1:0] ra0, ra1, wa0, wa1, ia;
         bit wide;
         wide = ($urandom_range(0, 7) == 0);
         ra0 = wide ? AW'($urandom) : AW'($urandom_range(0, 7));
         ra1 = AW'($urandom_range(0, 7));
         wa0 = AW'($urandom_range(0, 7));
         wa1 = wide ? AW'($urandom) : AW'($urandom_range(0, 7));
         ia  = AW'($urandom_range(0, 7));
         drive(ra0, ra1, 2'($urandom_range(0, 3)), wa0, wa1, $urandom, $urandom,
               1'($urandom_range(0, 1)), ia, ($urandom_range(0, 15) == 0));
      end

      idle_read('0, '0);
      repeat (3) @(posedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d exp=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
